input_skew_feeder: RTL and testbench

INPUT_SKEW_FEEDER -- requirements
Module: input_skew_feeder

---
 rtl/input_skew_feeder.sv | 133 +++++++++++++
 tb/tb_input_skew_feeder.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_skew_feeder.sv
// Skews an activation vector into a systolic array's left edge: lane i is delayed i cycles.
// Optional FEEDER_STATS_EN adds a per-tile accepted-vector counter on vec_count.
module input_skew_feeder #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   in_data,
  input  logic                 in_last,
  output logic [ROWS*DW-1:0]   out_left,
  output logic [ROWS-1:0]      out_go,
  output logic                 busy,
`ifdef FEEDER_STATS_EN
  output logic                 done,
  output logic [15:0]          vec_count
`else
  output logic                 done
`endif
);

  localparam int unsigned CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] DRAIN_INIT = CW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_drain_cnt;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            w_accept;
  logic            w_drain_end;

  // Ready is forced low in the same cycle reset is asserted.
  assign in_ready    = r_ready & ~rst;
  assign w_accept    = in_valid & in_ready;
  assign w_drain_end = (r_state == S_DRAIN) && (r_drain_cnt == '0);
  assign busy        = r_busy;
  assign done        = r_done;

  // Tile control: DRAIN lasts ROWS cycles so the deepest lane empties before done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_FEED: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (in_last) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= DRAIN_INIT;
              r_ready     <= 1'b0;
            end else begin
              r_state <= S_FEED;
              r_ready <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_drain_end) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-lane delay line; non-accept cycles enter as zero-data bubbles.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
    logic [DW-1:0] r_dat [gi+1];
    logic [gi:0]   r_go;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_go <= '0;
        for (int s = 0; s <= gi; s++) begin
          r_dat[s] <= '0;
        end
      end else begin
        r_go[0]  <= w_accept;
        r_dat[0] <= w_accept ? in_data[gi*DW +: DW] : '0;
        for (int s = 1; s <= gi; s++) begin
          r_go[s]  <= r_go[s-1];
          r_dat[s] <= r_dat[s-1];
        end
      end
    end

    assign out_left[gi*DW +: DW] = r_dat[gi];
    assign out_go[gi]            = r_go[gi];
  end

`ifdef FEEDER_STATS_EN
  logic [15:0] r_vec_count;

  // Counts accepted vectors in the current tile; cleared as done is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec_count <= '0;
    end else if (w_drain_end) begin
      r_vec_count <= '0;
    end else if (w_accept && (r_vec_count != 16'hFFFF)) begin
      r_vec_count <= r_vec_count + 16'd1;
    end
  end

  assign vec_count = r_vec_count;
`endif

endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed bench for input_skew_feeder: ROWS=4 main instance plus a ROWS=1 instance.
// Stats checks are compiled in only when FEEDER_STATS_EN is defined.
module tb_input_skew_feeder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] out_left;
  logic [3:0]  out_go;
  logic        busy;
  logic        done;

  logic        v1;
  logic        ready1;
  logic [7:0]  d1;
  logic        l1;
  logic [7:0]  left1;
  logic [0:0]  go1;
  logic        busy1;
  logic        done1;
`ifdef FEEDER_STATS_EN
  logic [15:0] vec_count;
  logic [15:0] vec_count1;
`endif

  int n_checks;
  int n_fail;

  logic [31:0] tv [8];
  logic [7:0]  tmask;
  int          last_idx;

  input_skew_feeder #(.ROWS(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_left(out_left), .out_go(out_go),
`ifdef FEEDER_STATS_EN
    .busy(busy), .done(done), .vec_count(vec_count)
`else
    .busy(busy), .done(done)
`endif
  );

  input_skew_feeder #(.ROWS(1), .DW(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ready1),
    .in_data(d1), .in_last(l1), .out_left(left1), .out_go(go1),
`ifdef FEEDER_STATS_EN
    .busy(busy1), .done(done1), .vec_count(vec_count1)
`else
    .busy(busy1), .done(done1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected skew output in cycle c (cycle c follows edge c-1) for the tile in tv/tmask.
  function automatic logic [3:0] exp_go(int c);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = c - 1 - i;
      if (j >= 0 && j < 8 && j <= last_idx) r[i] = tmask[j];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_left(int c);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = c - 1 - i;
      if (j >= 0 && j < 8 && j <= last_idx && tmask[j]) begin
        v = tv[j];
        r[i*8 +: 8] = v[i*8 +: 8];
      end
    end
    return r;
  endfunction

  // {in_ready, busy, done} for a tile whose last vector is accepted at edge L.
  function automatic logic [2:0] exp_ctl(int c, int L);
    if (c == 0)          return 3'b100;
    else if (c <= L)     return 3'b110;
    else if (c <= L + 4) return 3'b010;
    else if (c == L + 5) return 3'b101;
    else                 return 3'b100;
  endfunction

  // Drive the stimulus for edge c; invalid cycles carry garbage data and in_last=1.
  task automatic drive_edge(int c);
    logic vld;
    vld = (c >= 0 && c < 8 && c <= last_idx) ? tmask[c] : 1'b0;
    in_valid = vld;
    in_data  = vld ? tv[c] : 32'hDEADBEEF;
    in_last  = vld ? (c == last_idx) : 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    v1 = 1'b0; d1 = '0; l1 = 1'b0;
    tick(); tick();
    n_checks++;
    if ({in_ready, busy, done, out_go, out_left} !== {3'b000, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs ready/busy/done/go/left=%b%b%b/%b/%h expected 000/0000/00000000",
               in_ready, busy, done, out_go, out_left);
    end
    n_checks++;
    if ({ready1, busy1, done1, go1, left1} !== {3'b000, 1'b0, 8'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs_rows1 ready/busy/done/go/left=%b%b%b/%b/%h expected 000/0/00",
               ready1, busy1, done1, go1, left1);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b/%b expected 1/1", in_ready, ready1);
    end
  endtask

  task automatic test_single();
    logic [3:0]  eg [7];
    logic [31:0] el [7];
    eg = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    el = '{32'h0, 32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000, 32'h0, 32'h0};
    tv[0] = 32'h04030201; tmask = 8'b1; last_idx = 0;
    for (int c = 0; c < 7; c++) begin
      n_checks++;
      if (out_go !== eg[c] || out_left !== el[c]) begin
        n_fail++;
        $display("FAIL single_lanes c=%0d go=%b left=%h expected go=%b left=%h", c, out_go, out_left, eg[c], el[c]);
      end
      n_checks++;
      if ({in_ready, busy, done} !== exp_ctl(c, 0)) begin
        n_fail++;
        $display("FAIL single_ctl c=%0d ready/busy/done=%b expected %b", c, {in_ready, busy, done}, exp_ctl(c, 0));
      end
      drive_edge(c);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    tv[0] = 32'h0C0B0A09; tv[1] = 32'h08070605; tv[2] = 32'h04030201;
    tmask = 8'b111; last_idx = 2;
    for (int c = 0; c < 9; c++) begin
      n_checks++;
      if (out_go !== exp_go(c) || out_left !== exp_left(c)) begin
        n_fail++;
        $display("FAIL b2b_lanes c=%0d go=%b left=%h expected go=%b left=%h", c, out_go, out_left, exp_go(c), exp_left(c));
      end
      n_checks++;
      if ({in_ready, busy, done} !== exp_ctl(c, 2)) begin
        n_fail++;
        $display("FAIL b2b_ctl c=%0d ready/busy/done=%b expected %b", c, {in_ready, busy, done}, exp_ctl(c, 2));
      end
      if (c == 6) begin
        n_checks++;
        if (out_go !== 4'b1000 || out_left !== 32'h04000000) begin
          n_fail++;
          $display("FAIL b2b_lane3_last go=%b left=%h expected 1000/04000000", out_go, out_left);
        end
      end
      drive_edge(c);
      tick();
    end
  endtask

  task automatic test_bubble();
    tv[0] = 32'h44332211; tv[1] = 32'hEEEEEEEE; tv[2] = 32'h88776655;
    tmask = 8'b101; last_idx = 2;
    for (int c = 0; c < 9; c++) begin
      n_checks++;
      if (out_go !== exp_go(c) || out_left !== exp_left(c)) begin
        n_fail++;
        $display("FAIL bubble_lanes c=%0d go=%b left=%h expected go=%b left=%h", c, out_go, out_left, exp_go(c), exp_left(c));
      end
      n_checks++;
      if ({in_ready, busy, done} !== exp_ctl(c, 2)) begin
        n_fail++;
        $display("FAIL bubble_ctl c=%0d ready/busy/done=%b expected %b", c, {in_ready, busy, done}, exp_ctl(c, 2));
      end
      drive_edge(c);
      tick();
    end
  endtask

  task automatic test_reset_mid_tile();
    tv[0] = 32'h01010101; tv[1] = 32'h02020202; tv[2] = 32'h03030303; tv[3] = 32'h04040404;
    tmask = 8'b1111; last_idx = 3;
    drive_edge(0); tick();
    drive_edge(1); tick();
    drive_edge(2); rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_go !== 4'b0011) begin
      n_fail++;
      $display("FAIL midrst_during ready=%b go=%b expected 0/0011", in_ready, out_go);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, busy, done, out_go, out_left} !== {3'b100, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL midrst_after ready/busy/done/go/left=%b%b%b/%b/%h expected 100/0000/00000000",
               in_ready, busy, done, out_go, out_left);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || out_go !== 4'h0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_no_done c=%0d done=%b go=%b busy=%b expected 0/0000/0", c, done, out_go, busy);
      end
    end
  endtask

  task automatic test_drain_ignore();
    logic [3:0]  eg [9];
    logic [31:0] el [9];
    eg = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    el = '{32'h0, 32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[0] = 32'h04030201; tmask = 8'b1; last_idx = 0;
    for (int c = 0; c < 9; c++) begin
      n_checks++;
      if (out_go !== eg[c] || out_left !== el[c]) begin
        n_fail++;
        $display("FAIL drain_ignore c=%0d go=%b left=%h expected go=%b left=%h", c, out_go, out_left, eg[c], el[c]);
      end
      if (c == 5) begin
        n_checks++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL drain_ignore_done done=%b expected 1", done);
        end
      end
      if (c == 0) drive_edge(0);
      else if (c <= 4) begin
        in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_last = 1'b0;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_tile_after_done();
    in_valid = 1'b1; in_data = 32'h04030201; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick(); tick(); tick();
    n_checks++;
    if (done !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tad_done_cycle done=%b ready=%b expected 1/1", done, in_ready);
    end
    in_valid = 1'b1; in_data = 32'h44332211; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if ({out_go, out_left, busy, done, in_ready} !== {4'b0001, 32'h00000011, 3'b100}) begin
      n_fail++;
      $display("FAIL tad_next_tile go=%b left=%h busy/done/ready=%b%b%b expected 0001/00000011/100",
               out_go, out_left, busy, done, in_ready);
    end
    tick(); tick(); tick();
    n_checks++;
    if (out_go !== 4'b1000 || out_left !== 32'h44000000) begin
      n_fail++;
      $display("FAIL tad_lane3 go=%b left=%h expected 1000/44000000", out_go, out_left);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tad_second_done done=%b busy=%b expected 1/0", done, busy);
    end
    tick();
  endtask

  task automatic test_rows1();
    v1 = 1'b1; d1 = 8'h5A; l1 = 1'b1;
    #1;
    n_checks++;
    if (ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rows1_ready_idle ready=%b expected 1", ready1);
    end
    tick();
    v1 = 1'b1; d1 = 8'hA5; l1 = 1'b0;
    n_checks++;
    if ({go1, left1, ready1, busy1, done1} !== {1'b1, 8'h5A, 3'b010}) begin
      n_fail++;
      $display("FAIL rows1_out go=%b left=%h ready/busy/done=%b%b%b expected 1/5a/010",
               go1, left1, ready1, busy1, done1);
    end
    tick();
    v1 = 1'b0; l1 = 1'b0;
    n_checks++;
    if ({go1, left1, ready1, busy1, done1} !== {1'b0, 8'h00, 3'b101}) begin
      n_fail++;
      $display("FAIL rows1_done go=%b left=%h ready/busy/done=%b%b%b expected 0/00/101",
               go1, left1, ready1, busy1, done1);
    end
    tick();
    n_checks++;
    if (done1 !== 1'b0 || go1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rows1_after done=%b go=%b expected 0/0", done1, go1);
    end
  endtask

`ifdef FEEDER_STATS_EN
  task automatic test_stats();
    logic [15:0] ec [11];
    ec = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd5, 16'd5, 16'd5, 16'd0, 16'd0};
    for (int k = 0; k < 5; k++) tv[k] = 32'h10101010 * (k + 1);
    tmask = 8'b11111; last_idx = 4;
    for (int c = 0; c < 11; c++) begin
      n_checks++;
      if (vec_count !== ec[c]) begin
        n_fail++;
        $display("FAIL stats_count c=%0d vec_count=%0d expected %0d", c, vec_count, ec[c]);
      end
      if (c == 9) begin
        n_checks++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL stats_done done=%b expected 1", done);
        end
      end
      drive_edge(c);
      tick();
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_idx = -1;
    tmask    = '0;
    for (int k = 0; k < 8; k++) tv[k] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_bubble();
    test_reset_mid_tile();
    test_drain_ignore();
    test_tile_after_done();
    test_rows1();
`ifdef FEEDER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
